// File: rtl/exponent_bit_streamer_if.sv
// Load/stream handshake bundle between the exponent streamer and its
// producer (load side) and the Montgomery accumulator (bit side).
interface exponent_bit_streamer_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_N     = 2048
);
  localparam int IDX_W = $clog2(BITS_IN_N);

  logic                     valid_in;
  logic [REGISTER_SIZE-1:0] data_in;
  logic                     ready_out;
  logic                     reload_in;
  logic                     consumed_in;
  logic                     n_bit_out;
  logic                     bit_valid_out;
  logic [IDX_W-1:0]         bit_idx_out;
  logic                     last_bit_out;
  logic                     done_out;

  modport master (
    output valid_in, data_in, reload_in, consumed_in,
    input  ready_out, n_bit_out, bit_valid_out, bit_idx_out, last_bit_out, done_out
  );

  modport slave (
    input  valid_in, data_in, reload_in, consumed_in,
    output ready_out, n_bit_out, bit_valid_out, bit_idx_out, last_bit_out, done_out
  );
endinterface

// File: rtl/exponent_bit_streamer.sv
// Stores the Paillier modulus exponent N as REGISTER_SIZE-bit words and replays
// it one bit per consumed pulse, LSB first, cyclically until a reload.
module exponent_bit_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_N     = 2048
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  exponent_bit_streamer_if.slave bus
);
  localparam int WORDS  = BITS_IN_N / REGISTER_SIZE;
  localparam int IDX_W  = $clog2(BITS_IN_N);
  localparam int OFF_W  = $clog2(REGISTER_SIZE);
  localparam int LIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    LOAD,
    STREAM
  } state_e;

  state_e                   state_q;
  logic [LIDX_W-1:0]        loadIdx_q;
  logic [IDX_W-1:0]         bitIdx_q;
  logic [REGISTER_SIZE-1:0] curWord_q;
  logic                     done_q;
  logic [REGISTER_SIZE-1:0] words_q [WORDS];

  logic                     isLoad;
  logic                     accept;
  logic                     loadDone;
  logic                     atLastBit;
  logic                     atWordEnd;
  logic [LIDX_W-1:0]        nextWord;
  logic [REGISTER_SIZE-1:0] firstWord;

  assign isLoad    = (state_q == LOAD);
  assign accept    = isLoad && rst_n_in && bus.valid_in && !bus.reload_in;
  assign loadDone  = accept && (loadIdx_q == LIDX_W'(WORDS - 1));
  assign atLastBit = (bitIdx_q == IDX_W'(BITS_IN_N - 1));
  assign atWordEnd = (bitIdx_q[OFF_W-1:0] == OFF_W'(REGISTER_SIZE - 1));
  assign nextWord  = LIDX_W'(bitIdx_q >> OFF_W) + LIDX_W'(1);
  // A single-word exponent has not yet landed in the array when it is accepted.
  assign firstWord = (WORDS == 1) ? bus.data_in : words_q[0];

  assign bus.ready_out     = isLoad && rst_n_in;
  assign bus.bit_valid_out = !isLoad;
  assign bus.last_bit_out  = !isLoad && atLastBit;
  assign bus.n_bit_out     = curWord_q[0];
  assign bus.bit_idx_out   = bitIdx_q;
  assign bus.done_out      = done_q;

  // Exponent storage is deliberately not reset; a reload overwrites it in full.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      words_q[loadIdx_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= LOAD;
      loadIdx_q <= '0;
      bitIdx_q  <= '0;
      curWord_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.reload_in) begin
        state_q   <= LOAD;
        loadIdx_q <= '0;
      end else if (state_q == STREAM) begin
        if (bus.consumed_in) begin
          if (atLastBit) begin
            bitIdx_q  <= '0;
            curWord_q <= words_q[0];
            done_q    <= 1'b1;
          end else if (atWordEnd) begin
            bitIdx_q  <= bitIdx_q + IDX_W'(1);
            curWord_q <= words_q[nextWord];
          end else begin
            bitIdx_q  <= bitIdx_q + IDX_W'(1);
            curWord_q <= curWord_q >> 1;
          end
        end
      end else if (accept) begin
        if (loadDone) begin
          state_q   <= STREAM;
          loadIdx_q <= '0;
          bitIdx_q  <= '0;
          curWord_q <= firstWord;
        end else begin
          loadIdx_q <= loadIdx_q + LIDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_exponent_bit_streamer.sv
// Directed-vector bench for exponent_bit_streamer: load, cyclic replay,
// wrap/done, reload priority, mid-load reset and ignored-input cases.
module tb_exponent_bit_streamer;
  localparam int REGISTER_SIZE = 32;
  localparam int BITS_IN_N     = 2048;
  localparam int WORDS         = BITS_IN_N / REGISTER_SIZE;

  logic clk_in;
  logic rst_n_in;

  int compared;
  int mismatched;

  logic [31:0] model [WORDS];

  exponent_bit_streamer_if #(.REGISTER_SIZE(REGISTER_SIZE), .BITS_IN_N(BITS_IN_N)) bus ();

  exponent_bit_streamer #(.REGISTER_SIZE(REGISTER_SIZE), .BITS_IN_N(BITS_IN_N)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expBit(input int idx);
    logic [31:0] w;
    w = model[idx / 32];
    return w[idx % 32];
  endfunction

  task automatic applyStimulus(input int idx);
    @(negedge clk_in);
    bus.valid_in = 1'b1;
    bus.data_in  = model[idx];
  endtask

  task automatic idle();
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
  endtask

  task automatic loadAll();
    for (int i = 0; i < WORDS; i++) applyStimulus(i);
    idle();
  endtask

  // Holds consumed_in high for n consecutive edges, then drops it.
  task automatic stepBits(input int n);
    @(negedge clk_in);
    bus.consumed_in = 1'b1;
    repeat (n) @(negedge clk_in);
    bus.consumed_in = 1'b0;
  endtask

  initial begin
    int doneCount;
    int lastCount;
    compared   = 0;
    mismatched = 0;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.reload_in   = 1'b0;
    bus.consumed_in = 1'b0;
    rst_n_in        = 1'b0;

    #3;
    checkOutput("rst ready", bus.ready_out, 0);
    checkOutput("rst bvalid", bus.bit_valid_out, 0);
    checkOutput("rst nbit", bus.n_bit_out, 0);
    checkOutput("rst idx", bus.bit_idx_out, 0);
    checkOutput("rst last", bus.last_bit_out, 0);
    checkOutput("rst done", bus.done_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    checkOutput("post-rst ready", bus.ready_out, 1);

    // A5A5A5A5 pattern: LSB-first 1,0,1,0,0,1,0,1 per byte
    for (int i = 0; i < WORDS; i++) model[i] = 32'hA5A5_A5A5;
    loadAll();
    checkOutput("t1 bvalid", bus.bit_valid_out, 1);
    checkOutput("t1 ready", bus.ready_out, 0);
    checkOutput("t1 nbit0", bus.n_bit_out, 1);
    checkOutput("t1 idx0", bus.bit_idx_out, 0);
    for (int k = 1; k <= 32; k++) begin
      stepBits(1);
      checkOutput($sformatf("t1 nbit%0d", k), bus.n_bit_out, 32'(expBit(k)));
    end
    checkOutput("t1 idx32", bus.bit_idx_out, 32);

    // word[i] = i
    @(negedge clk_in);
    bus.reload_in = 1'b1;
    @(negedge clk_in);
    bus.reload_in = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'(i);
    loadAll();
    checkOutput("t2 nbit0", bus.n_bit_out, 0);
    stepBits(32);
    checkOutput("t2 idx32", bus.bit_idx_out, 32);
    checkOutput("t2 nbit32", bus.n_bit_out, 1);
    stepBits(32);
    checkOutput("t2 idx64", bus.bit_idx_out, 64);
    checkOutput("t2 nbit64", bus.n_bit_out, 0);
    stepBits(1);
    checkOutput("t2 nbit65", bus.n_bit_out, 1);
    stepBits(BITS_IN_N - 1 - 65);
    checkOutput("t3 idx2047", bus.bit_idx_out, 2047);
    checkOutput("t3 last", bus.last_bit_out, 1);
    checkOutput("t3 nbit2047", bus.n_bit_out, 0);
    stepBits(1);
    checkOutput("t3 wrap done", bus.done_out, 1);
    checkOutput("t3 wrap idx", bus.bit_idx_out, 0);
    checkOutput("t3 wrap last", bus.last_bit_out, 0);
    @(negedge clk_in);
    checkOutput("t3 done width", bus.done_out, 0);

    // Full back-to-back replay from idx 0
    doneCount = 0;
    lastCount = 0;
    bus.consumed_in = 1'b1;
    for (int j = 0; j < BITS_IN_N; j++) begin
      @(negedge clk_in);
      if (bus.done_out) doneCount++;
      if (bus.last_bit_out) lastCount++;
      if (j == BITS_IN_N - 2) checkOutput("t3 b2b last", bus.last_bit_out, 1);
    end
    bus.consumed_in = 1'b0;
    @(negedge clk_in);
    if (bus.done_out) doneCount++;
    checkOutput("t3 b2b dones", doneCount, 1);
    checkOutput("t3 b2b lasts", lastCount, 1);
    checkOutput("t3 b2b idx", bus.bit_idx_out, 0);
    checkOutput("t3 b2b nbit", bus.n_bit_out, 32'(expBit(0)));

    // reload coinciding with consumed at the final bit
    stepBits(BITS_IN_N - 1);
    checkOutput("t4 idx2047", bus.bit_idx_out, 2047);
    @(negedge clk_in);
    bus.reload_in   = 1'b1;
    bus.consumed_in = 1'b1;
    @(negedge clk_in);
    bus.reload_in   = 1'b0;
    bus.consumed_in = 1'b0;
    checkOutput("t4 no done", bus.done_out, 0);
    checkOutput("t4 ready", bus.ready_out, 1);
    checkOutput("t4 bvalid", bus.bit_valid_out, 0);
    checkOutput("t4 last", bus.last_bit_out, 0);
    for (int i = 0; i < WORDS; i++) model[i] = 32'hFFFF_FFFF;
    loadAll();
    checkOutput("t4 nbit", bus.n_bit_out, 1);
    checkOutput("t4 bvalid2", bus.bit_valid_out, 1);

    // valid_in during STREAM is ignored
    stepBits(5);
    applyStimulus(0);
    bus.data_in = '0;
    repeat (3) @(negedge clk_in);
    bus.valid_in = 1'b0;
    checkOutput("t6 stream idx", bus.bit_idx_out, 5);
    checkOutput("t6 stream nbit", bus.n_bit_out, 1);
    checkOutput("t6 stream ready", bus.ready_out, 0);

    // consumed_in during LOAD is ignored
    @(negedge clk_in);
    bus.reload_in = 1'b1;
    @(negedge clk_in);
    bus.reload_in = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'h5A5A_0000 | 32'(i);
    for (int i = 0; i < 10; i++) applyStimulus(i);
    idle();
    stepBits(1);
    checkOutput("t6 load ready", bus.ready_out, 1);
    checkOutput("t6 load bvalid", bus.bit_valid_out, 0);
    checkOutput("t6 load idx", bus.bit_idx_out, 5);
    for (int i = 10; i < WORDS - 1; i++) applyStimulus(i);
    idle();
    checkOutput("t6 63 blocks", bus.bit_valid_out, 0);
    applyStimulus(WORDS - 1);
    idle();
    checkOutput("t6 64 blocks", bus.bit_valid_out, 1);
    checkOutput("t6 nbit0", bus.n_bit_out, 0);
    stepBits(32);
    checkOutput("t6 nbit32", bus.n_bit_out, 1);

    // reset after 30 stale blocks
    @(negedge clk_in);
    bus.reload_in = 1'b1;
    @(negedge clk_in);
    bus.reload_in = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 31; i++) applyStimulus(i);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkOutput("t5 rst ready", bus.ready_out, 0);
    checkOutput("t5 rst bvalid", bus.bit_valid_out, 0);
    checkOutput("t5 rst nbit", bus.n_bit_out, 0);
    checkOutput("t5 rst idx", bus.bit_idx_out, 0);
    checkOutput("t5 rst last", bus.last_bit_out, 0);
    idle();
    rst_n_in = 1'b1;
    for (int i = 0; i < WORDS; i++) model[i] = 32'hC3C3_0000 | 32'(i);
    for (int i = 0; i < WORDS - 1; i++) applyStimulus(i);
    idle();
    checkOutput("t5 63 blocks", bus.bit_valid_out, 0);
    applyStimulus(WORDS - 1);
    idle();
    checkOutput("t5 bvalid", bus.bit_valid_out, 1);
    checkOutput("t5 nbit0", bus.n_bit_out, 0);
    checkOutput("t5 idx0", bus.bit_idx_out, 0);
    stepBits(32);
    checkOutput("t5 nbit32", bus.n_bit_out, 1);
    stepBits(1);
    checkOutput("t5 nbit33", bus.n_bit_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
